mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory (M) stage of the 5-stage RV32I pipeline. Consumes the EX/MEM register fields, performs load/store accesses over a request/response data-memory port, and aligns and extends load data.
- Produces the registered MEM/WB fields and drives a stall request to the hazard unit while an access is outstanding.
- Includes a watchdog that aborts hung bus transactions.

Parameters:
- TIMEOUT, 16, maximum cycles an access may wait for ready/rvalid before abort (≥2).
- CNT_W, 5, width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- ValidM  in  1  EX/MEM slot holds a real instruction (0 = bubble)
- RegWriteM  in  1  EX/MEM ctrl
- ResultSrcM  in  2  EX/MEM ctrl: 00 ALU, 01 load, 10 PC+4, 11 ImmExt
- MemWriteM  in  1  EX/MEM ctrl, store
- funct3M  in  3  EX/MEM ctrl, access size/sign
- ALUResultM  in  32  effective address / ALU result
- WriteDataM  in  32  store data (rs2)
- PCPlus4M  in  32  EX/MEM data
- ImmExtM  in  32  EX/MEM data
- RdM  in  5  destination register
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({ALUResultM[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ready  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data word
- StallM  out  1  hold IF..EX/MEM this cycle
- ValidW, RegWriteW  out  1 each  MEM/WB ctrl
- ResultSrcW  out  2  MEM/WB ctrl
- ALUResultW, ReadDataW, PCPlus4W, ImmExtW  out  32 each  MEM/WB data
- RdW  out  5  MEM/WB data
- MisalignW  out  1  exception flag for the instruction in WB
- BusErrW  out  1  exception flag for the instruction in WB

Behaviour:
- Op classification:
  - load = ValidM & ResultSrcM==01.
  - store = ValidM & MemWriteM.
  - access = load | store.
- Size legality:
  - Loads accept funct3 000/001/010/100/101.
  - Stores accept funct3 000/001/010.
  - Any other funct3 raises MisalignW.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Violation raises MisalignW.
- Misalign handling: no dmem_req, no stall; the instruction retires next edge with RegWriteW=0 and MisalignW=1.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{WD[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{WD[15:0]}}.
  - SW: be=1111, wdata=WD.
- Load extract:
  - Select the byte/half from dmem_rdata by addr[1:0].
  - Sign-extend for 000/001; zero-extend for 100/101.
- FSM states: IDLE, REQ, RESP.
  - IDLE:
    - If access is legal, assert dmem_req combinationally.
    - Store with dmem_ready=1: completes this cycle, no stall.
    - Load with dmem_ready=1: go to RESP.
    - dmem_ready=0: go to REQ.
    - dmem_rvalid is ignored in IDLE.
  - REQ: hold dmem_req and all dmem_* outputs stable until dmem_ready. Then a store completes; a load goes to RESP.
  - RESP: dmem_req=0. On dmem_rvalid the load completes and the FSM returns to IDLE.
- StallM = access & legal & ~complete (combinational). A load always stalls at least 1 cycle. Upstream holds EX/MEM inputs stable while StallM=1.
- Watchdog:
  - Counter clears in IDLE and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT-1 without completion: abort, return to IDLE, and retire with BusErrW=1, RegWriteW=0, StallM=0 that cycle.
- MEM/WB register, updated every edge:
  - StallM=1: capture a bubble (ValidW=0, RegWriteW=0, flags 0).
  - Otherwise: capture the M fields.
  - ReadDataW = extracted load data for loads, 0 otherwise.
  - A non-access instruction or bubble passes through in 1 cycle.
- Reset:
  - FSM to IDLE, counter 0, dmem_req=0.
  - All W outputs 0.
  - Reset mid-access abandons the transaction; any late rvalid is ignored.

Test Plan:
- LW, addr 0x100, ready=1 in IDLE, rvalid 2 cycles later with rdata 0xDEADBEEF → StallM high 2 cycles; then ReadDataW=0xDEADBEEF, RegWriteW=1.
- LB at 0x103, rdata 0x80xxxxxx → ReadDataW=0xFFFFFF80; same access with LBU → 0x00000080.
- SH at 0x202, WD=0x1234ABCD, ready=1 → dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200, StallM=0.
- LW at 0x101 → no dmem_req, MisalignW=1, RegWriteW=0, no stall.
- SW with dmem_ready held low, TIMEOUT=16 → dmem_req held stable; abort after 16 cycles, BusErrW=1, FSM returns to IDLE.
- reset asserted in RESP, then rvalid arrives → all W outputs 0, no write-back, FSM stays IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// RV32I memory stage: load/store sequencing over a req/resp data port, load alignment
// and extension, bus watchdog, and the MEM/WB pipeline register.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidM,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ImmExtM,
  input  logic [4:0]  RdM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        ValidW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ImmExtW,
  output logic [4:0]  RdW,
  output logic        MisalignW,
  output logic        BusErrW
);

  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, RESP = 2'b10} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        is_load, is_store, access, size_ok, align_ok, legal, go, misalign;
  logic        complete, abort, req;
  logic [3:0]  be;
  logic [31:0] wdata, rd_shift, load_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  logic        valid_w_q, valid_w_d, regwrite_w_q, regwrite_w_d;
  logic        misalign_w_q, misalign_w_d, buserr_w_q, buserr_w_d;
  logic [1:0]  resultsrc_w_q, resultsrc_w_d;
  logic [31:0] aluresult_w_q, aluresult_w_d, readdata_w_q, readdata_w_d;
  logic [31:0] pcplus4_w_q, pcplus4_w_d, immext_w_q, immext_w_d;
  logic [4:0]  rd_w_q, rd_w_d;

  assign is_load  = ValidM & (ResultSrcM == 2'b01);
  assign is_store = ValidM & MemWriteM;
  assign access   = is_load | is_store;

  // Size and alignment legality of the current access
  always_comb begin
    size_ok  = 1'b0;
    align_ok = 1'b1;
    if (is_store) begin
      size_ok = (funct3M == 3'b000) | (funct3M == 3'b001) | (funct3M == 3'b010);
    end else begin
      size_ok = (funct3M == 3'b000) | (funct3M == 3'b001) | (funct3M == 3'b010) |
                (funct3M == 3'b100) | (funct3M == 3'b101);
    end
    case (funct3M[1:0])
      2'b01:   align_ok = (ALUResultM[0] == 1'b0);
      2'b10:   align_ok = (ALUResultM[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  assign legal    = size_ok & align_ok;
  assign go       = access & legal;
  assign misalign = access & ~legal;

  // Store byte lanes and lane-replicated write data
  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0000_0000;
    case (funct3M[1:0])
      2'b00: begin
        be    = 4'b0001 << ALUResultM[1:0];
        wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WriteDataM[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wdata = WriteDataM;
      end
      default: begin
        be    = 4'b0000;
        wdata = 32'h0000_0000;
      end
    endcase
  end

  assign rd_shift = dmem_rdata >> {ALUResultM[1:0], 3'b000};
  assign rd_byte  = rd_shift[7:0];
  assign rd_half  = ALUResultM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  // Load data extraction and sign/zero extension
  always_comb begin
    load_data = 32'h0000_0000;
    case (funct3M)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'h00_0000, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'h0000, rd_half};
      3'b010:  load_data = dmem_rdata;
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Access sequencing: completion, watchdog abort and next state
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    req      = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        req      = go;
        complete = go & is_store & dmem_ready;
      end
      REQ: begin
        req      = 1'b1;
        complete = is_store & dmem_ready;
      end
      RESP: begin
        req      = 1'b0;
        complete = dmem_rvalid;
      end
      default: begin
        req      = 1'b0;
        complete = 1'b0;
      end
    endcase
    if (state_q != IDLE) begin
      abort = ~complete & (cnt_q == CNT_W'(TIMEOUT - 1));
    end else begin
      abort = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (go & ~complete) begin
          state_d = (dmem_ready & is_load) ? RESP : REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (complete | abort) begin
          state_d = IDLE;
        end else if (dmem_ready) begin
          state_d = RESP;
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        if (complete | abort) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == IDLE) || (state_d == IDLE)) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign StallM     = go & ~complete & ~abort;
  assign dmem_req   = req;
  assign dmem_we    = is_store;
  assign dmem_addr  = {ALUResultM[31:2], 2'b00};
  assign dmem_be    = be;
  assign dmem_wdata = wdata;

  // MEM/WB next values: bubble while stalled, otherwise the retiring instruction
  always_comb begin
    valid_w_d     = 1'b0;
    regwrite_w_d  = 1'b0;
    misalign_w_d  = 1'b0;
    buserr_w_d    = 1'b0;
    resultsrc_w_d = 2'b00;
    aluresult_w_d = 32'h0000_0000;
    readdata_w_d  = 32'h0000_0000;
    pcplus4_w_d   = 32'h0000_0000;
    immext_w_d    = 32'h0000_0000;
    rd_w_d        = 5'd0;
    if (StallM) begin
      valid_w_d = 1'b0;
    end else begin
      valid_w_d     = ValidM;
      regwrite_w_d  = ValidM & RegWriteM & ~misalign & ~abort;
      misalign_w_d  = misalign;
      buserr_w_d    = abort;
      resultsrc_w_d = ResultSrcM;
      aluresult_w_d = ALUResultM;
      readdata_w_d  = (is_load & legal & complete) ? load_data : 32'h0000_0000;
      pcplus4_w_d   = PCPlus4M;
      immext_w_d    = ImmExtM;
      rd_w_d        = RdM;
    end
  end

  // State, watchdog counter and MEM/WB registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      valid_w_q     <= 1'b0;
      regwrite_w_q  <= 1'b0;
      misalign_w_q  <= 1'b0;
      buserr_w_q    <= 1'b0;
      resultsrc_w_q <= 2'b00;
      aluresult_w_q <= 32'h0000_0000;
      readdata_w_q  <= 32'h0000_0000;
      pcplus4_w_q   <= 32'h0000_0000;
      immext_w_q    <= 32'h0000_0000;
      rd_w_q        <= 5'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      valid_w_q     <= valid_w_d;
      regwrite_w_q  <= regwrite_w_d;
      misalign_w_q  <= misalign_w_d;
      buserr_w_q    <= buserr_w_d;
      resultsrc_w_q <= resultsrc_w_d;
      aluresult_w_q <= aluresult_w_d;
      readdata_w_q  <= readdata_w_d;
      pcplus4_w_q   <= pcplus4_w_d;
      immext_w_q    <= immext_w_d;
      rd_w_q        <= rd_w_d;
    end
  end

  assign ValidW     = valid_w_q;
  assign RegWriteW  = regwrite_w_q;
  assign MisalignW  = misalign_w_q;
  assign BusErrW    = buserr_w_q;
  assign ResultSrcW = resultsrc_w_q;
  assign ALUResultW = aluresult_w_q;
  assign ReadDataW  = readdata_w_q;
  assign PCPlus4W   = pcplus4_w_q;
  assign ImmExtW    = immext_w_q;
  assign RdW        = rd_w_q;

endmodule
